fpga_pll_ctrl: RTL
==================

FPGA_PLL_CTRL -- requirements
Module: fpga_pll_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16, meaning the number of clk_ext cycles pll_reset is held per apply.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 27000, meaning the maximum clk_ext cycles to wait for lock per attempt (1 ms at 27 MHz).
REQ-003 SHALL have parameter LOCK_STABLE, default 256, meaning the number of consecutive synchronized-lock-high cycles required before release.
REQ-004 SHALL have parameter MAX_RETRY, default 3, meaning the number of re-applies allowed after the first timeout.
REQ-005 SHALL have parameter BOOT_MODE, default 0, meaning the mode applied after reset.
REQ-006 SHALL have port clk_ext, input, 1 bit: the 27 MHz reference clock; the controller runs only on this clock.
REQ-007 SHALL have port arst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port mode_req, input, 2 bits: the requested video mode.
REQ-009 SHALL have port mode_vld, input, 1 bit: request valid; a transfer occurs when mode_vld=1 and mode_rdy=1 on the same cycle.
REQ-010 SHALL have port mode_rdy, output, 1 bit: controller accepts a request.
REQ-011 SHALL have port pll_lock, input, 1 bit: the rPLL LOCK output, asynchronous to clk_ext.
REQ-012 SHALL have port pll_reset, output, 1 bit: drives the rPLL RESET input.
REQ-013 SHALL have ports idsel, fbdsel and odsel, outputs, 6 bits each: drive the rPLL IDSEL, FBDSEL and ODSEL inputs.
REQ-014 SHALL have port mode_cur, output, 2 bits: the mode currently applied.
REQ-015 SHALL have port srst_n, output, 1 bit: downstream reset, high only while the PLL is locked and stable.
REQ-016 SHALL have port busy, output, 1 bit: a reconfiguration is in progress.
REQ-017 SHALL have port err_lock, output, 1 bit: sticky flag set on retry exhaustion.
REQ-018 SHALL have port err_mode, output, 1 bit: a one-cycle pulse on an accepted reserved mode.

Function
REQ-019 SHALL synchronize pll_lock through 2 flip-flops into lock_s; every lock decision SHALL use lock_s only.
REQ-020 SHALL use this mode table, given as (IDIV, FBDIV, ODIV) divider-select values: mode 0 = (3, 54, 2), 1280x720; mode 1 = (2, 13, 4), 640x480; modes 2 and 3 are reserved.
REQ-021 SHALL drive idsel, fbdsel and odsel as the bitwise complement of the 6-bit table values, which is the GoWin dynamic-select encoding (mode 0: idsel=6'h3C, fbdsel=6'h09, odsel=6'h3D).
REQ-022 SHALL implement FSM states IDLE, APPLY, WAIT_LOCK, STABLE, RUN, FAIL, with one shared 16-bit cycle counter cnt and a 2-bit retry counter rty.
REQ-023 APPLY: SHALL register the selects from mode_cur, set pll_reset=1 and srst_n=0, hold for RST_CYCLES cycles, then go to WAIT_LOCK with cnt=0.
REQ-024 WAIT_LOCK: pll_reset=0. If lock_s=1, go to STABLE with cnt=0. Else if cnt reaches LOCK_TIMEOUT-1: when rty<MAX_RETRY, increment rty and go to APPLY; otherwise set err_lock=1 and go to FAIL.
REQ-025 STABLE: lock_s=0 SHALL return the FSM to WAIT_LOCK with cnt=0 and rty unchanged; LOCK_STABLE consecutive lock_s=1 cycles SHALL go to RUN and clear rty.
REQ-026 RUN: srst_n=1; lock_s=0 SHALL force srst_n=0 in the same cycle and go to APPLY with the same mode, with no err flag.
REQ-027 mode_rdy SHALL be 1 only in RUN and FAIL; busy SHALL be 1 in APPLY, WAIT_LOCK and STABLE.
REQ-028 An accepted request for mode 0 or 1 SHALL load mode_cur, clear err_lock and rty, and go to APPLY, even when the requested mode equals mode_cur.
REQ-029 An accepted request for mode 2 or 3 SHALL pulse err_mode for 1 cycle and leave the state, mode_cur and selects unchanged.
REQ-030 mode_vld asserted while mode_rdy=0 SHALL be ignored, not queued.
REQ-031 srst_n SHALL be a registered output, synchronous to clk_ext; consumers resynchronize it into their own domains.
REQ-032 The selects SHALL change only on APPLY entry, while pll_reset=1.

Reset
REQ-033 On arst_n=0 the block SHALL asynchronously set: state=APPLY, mode_cur=BOOT_MODE, selects=BOOT_MODE values, pll_reset=1, srst_n=0, busy=1, mode_rdy=0, err_lock=0, err_mode=0, cnt=0, rty=0, lock synchronizer=0.
REQ-034 Deassertion of arst_n SHALL start the APPLY count on the first clk_ext edge.
REQ-035 arst_n asserted mid-sequence SHALL abort the sequence with no residual retry or error state.

Verification
REQ-036 Boot: release reset; pll_lock rises 100 cycles after pll_reset falls and is held -> pll_reset high for exactly 16 cycles; srst_n rises 2+256+1 cycles after the lock rise (±1 cycle); idsel=6'h3C, fbdsel=6'h09, odsel=6'h3D.
REQ-037 Mode switch: in RUN, mode_vld=1 with mode_req=1 -> mode_rdy drops next cycle; selects=6'h3D/6'h32/6'h3B while pll_reset=1; srst_n=0 until relock+256.
REQ-038 Lock glitch in STABLE: pll_lock low for 3 cycles at 200 cycles into STABLE -> FSM returns to WAIT_LOCK; srst_n is released 256 cycles after the second stable lock; err_lock=0.
REQ-039 Timeout exhaustion: pll_lock held at 0 -> exactly 4 APPLY pulses of 16 cycles, each followed by a 27000-cycle wait; then err_lock=1, mode_rdy=1, srst_n=0; a new request for mode 0 clears err_lock.
REQ-040 Reserved mode and lock loss: mode_req=2 in RUN -> err_mode 1-cycle pulse, srst_n stays 1; pll_lock dropped in RUN -> srst_n=0 within 3 cycles, then a re-apply of the same mode.

Source files
------------

// File: rtl/fpga_pll_ctrl.sv
// Reset, lock-supervision and dynamic divider-select controller for a GoWin rPLL.
// Runs entirely on clk_ext; pll_lock is resynchronized before any decision uses it.
module fpga_pll_ctrl #(
   parameter int         RST_CYCLES   = 16,
   parameter int         LOCK_TIMEOUT = 27000,
   parameter int         LOCK_STABLE  = 256,
   parameter int         MAX_RETRY    = 3,
   parameter logic [1:0] BOOT_MODE    = 2'd0
) (
   input  logic       clk_ext,
   input  logic       arst_n,
   input  logic [1:0] mode_req,
   input  logic       mode_vld,
   output logic       mode_rdy,
   input  logic       pll_lock,
   output logic       pll_reset,
   output logic [5:0] idsel,
   output logic [5:0] fbdsel,
   output logic [5:0] odsel,
   output logic [1:0] mode_cur,
   output logic       srst_n,
   output logic       busy,
   output logic       err_lock,
   output logic       err_mode
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] APPLY     = 3'd1;
   localparam logic [2:0] WAIT_LOCK = 3'd2;
   localparam logic [2:0] STABLE    = 3'd3;
   localparam logic [2:0] RUN       = 3'd4;
   localparam logic [2:0] FAIL      = 3'd5;

   localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
   localparam logic [15:0] TO_LAST  = 16'(LOCK_TIMEOUT - 1);
   localparam logic [15:0] STB_LAST = 16'(LOCK_STABLE - 1);
   localparam logic [1:0]  RTY_MAX  = 2'(MAX_RETRY);

   // GoWin dynamic selects take the complement of the divider value.
   function automatic logic [17:0] sel_of(input logic [1:0] m);
      logic [17:0] s;
      case (m)
         2'd1:    s = ~{6'd2, 6'd13, 6'd4};
         default: s = ~{6'd3, 6'd54, 6'd2};
      endcase
      return s;
   endfunction

   logic [1:0]  sync_q;
   logic        lock_s;
   logic [2:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  rty_q, rty_d;
   logic [1:0]  mode_q, mode_d;
   logic [17:0] sel_q, sel_d;
   logic        err_lock_q, err_lock_d;
   logic        err_mode_q, err_mode_d;
   logic        srst_q;
   logic        accept;

   assign lock_s   = sync_q[1];
   assign mode_rdy = (state_q == RUN) || (state_q == FAIL);
   assign busy     = (state_q == APPLY) || (state_q == WAIT_LOCK) || (state_q == STABLE);
   assign accept   = mode_rdy && mode_vld;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rty_d      = rty_q;
      mode_d     = mode_q;
      err_lock_d = err_lock_q;
      err_mode_d = 1'b0;
      case (state_q)
         APPLY: begin
            if (cnt_q == RST_LAST) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_d = STABLE;
               cnt_d   = '0;
            end else if (cnt_q == TO_LAST) begin
               cnt_d = '0;
               if (rty_q < RTY_MAX) begin
                  rty_d   = rty_q + 2'd1;
                  state_d = APPLY;
               end else begin
                  err_lock_d = 1'b1;
                  state_d    = FAIL;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         STABLE: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == STB_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
               rty_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RUN, FAIL: begin
            if (state_q == RUN && !lock_s) begin
               state_d = APPLY;
               cnt_d   = '0;
            end
            if (accept) begin
               if (!mode_req[1]) begin
                  mode_d     = mode_req;
                  err_lock_d = 1'b0;
                  rty_d      = '0;
                  state_d    = APPLY;
                  cnt_d      = '0;
               end else begin
                  err_mode_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = APPLY;
            cnt_d   = '0;
         end
      endcase
      // Selects move only when entering APPLY, i.e. while the PLL is held in reset.
      sel_d = (state_d == APPLY && state_q != APPLY) ? sel_of(mode_d) : sel_q;
   end

   always_ff @(posedge clk_ext or negedge arst_n) begin
      if (!arst_n) begin
         sync_q     <= '0;
         state_q    <= APPLY;
         cnt_q      <= '0;
         rty_q      <= '0;
         mode_q     <= BOOT_MODE;
         sel_q      <= sel_of(BOOT_MODE);
         err_lock_q <= 1'b0;
         err_mode_q <= 1'b0;
         srst_q     <= 1'b0;
      end else begin
         sync_q     <= {sync_q[0], pll_lock};
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rty_q      <= rty_d;
         mode_q     <= mode_d;
         sel_q      <= sel_d;
         err_lock_q <= err_lock_d;
         err_mode_q <= err_mode_d;
         srst_q     <= (state_d == RUN);
      end
   end

   assign pll_reset = (state_q == APPLY);
   assign idsel     = sel_q[17:12];
   assign fbdsel    = sel_q[11:6];
   assign odsel     = sel_q[5:0];
   assign mode_cur  = mode_q;
   assign srst_n    = srst_q;
   assign err_lock  = err_lock_q;
   assign err_mode  = err_mode_q;

endmodule
